// File: rtl/apuf_xor_eval_ctrl.sv
// k-XOR arbiter-PUF evaluation controller: challenge handshake, trigger sequencing, response XOR.
// Optional APUF_MAJVOTE_EN repeats each evaluation N_VOTE times and majority-votes per chain.
module apuf_xor_eval_ctrl #(
  parameter int unsigned N_STAGE    = 64,
  parameter int unsigned N_CHAIN    = 4,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned TIMEOUT_W  = 8,
  parameter int unsigned N_VOTE     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ch_valid,
  output logic               ch_ready,
  input  logic [N_STAGE-1:0] ch_data,
  output logic [N_STAGE-1:0] chal_out,
  output logic               tig_out,
  input  logic [N_CHAIN-1:0] chain_rdy,
  input  logic [N_CHAIN-1:0] chain_bit,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_bit,
  output logic [N_CHAIN-1:0] resp_raw,
  output logic               resp_err
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned CntW    = (TIMEOUT_W > SettleW) ? TIMEOUT_W : SettleW;
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TmoCnt     = CntW'((2 ** TIMEOUT_W) - 1);

  typedef enum logic [2:0] {
    StIdle, StLoad, StFire, StWait, StSample, StRelax, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic               quiet_q, quiet_d;
  logic               err_q, err_d;
  logic [N_STAGE-1:0] chal_q, chal_d;
  logic               tig_q, tig_d;
  logic               ch_ready_q, ch_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_bit_q, resp_bit_d;
  logic [N_CHAIN-1:0] resp_raw_q, resp_raw_d;
  logic               relax_end, relax_tmo, done_entry;

  // Chains are asynchronous sources: two-flop synchronisers on every line.
  logic [N_CHAIN-1:0] rdy_meta_q, rdy_sync_q, bit_meta_q, bit_sync_q;
  logic               rdy_all, rdy_none;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_meta_q <= '0;
      rdy_sync_q <= '0;
      bit_meta_q <= '0;
      bit_sync_q <= '0;
    end else begin
      rdy_meta_q <= chain_rdy;
      rdy_sync_q <= rdy_meta_q;
      bit_meta_q <= chain_bit;
      bit_sync_q <= bit_meta_q;
    end
  end

  assign rdy_all  = &rdy_sync_q;
  assign rdy_none = ~|rdy_sync_q;
  assign cnt_inc  = cnt_q + CntW'(1);

`ifdef APUF_MAJVOTE_EN
  localparam int unsigned VoteW = $clog2(N_VOTE + 1);
  localparam logic [VoteW-1:0] VoteHalf = VoteW'(N_VOTE / 2);
  localparam logic [VoteW-1:0] VoteLast = VoteW'(N_VOTE - 1);

  logic [VoteW-1:0]   ones_q [N_CHAIN];
  logic [VoteW-1:0]   ones_d [N_CHAIN];
  logic [VoteW-1:0]   vote_q, vote_d;
  logic [N_CHAIN-1:0] maj;

  always_comb begin
    for (int i = 0; i < N_CHAIN; i++) begin
      maj[i] = (ones_q[i] > VoteHalf);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_q <= '0;
      for (int i = 0; i < N_CHAIN; i++) begin
        ones_q[i] <= '0;
      end
    end else begin
      vote_q <= vote_d;
      for (int i = 0; i < N_CHAIN; i++) begin
        ones_q[i] <= ones_d[i];
      end
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quiet_d      = quiet_q;
    err_d        = err_q;
    chal_d       = chal_q;
    tig_d        = tig_q;
    ch_ready_d   = ch_ready_q;
    resp_valid_d = resp_valid_q;
    resp_bit_d   = resp_bit_q;
    resp_raw_d   = resp_raw_q;
    relax_end    = 1'b0;
    relax_tmo    = 1'b0;
    done_entry   = 1'b0;
`ifdef APUF_MAJVOTE_EN
    vote_d = vote_q;
    ones_d = ones_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (ch_valid) begin
          chal_d     = ch_data;
          cnt_d      = '0;
          err_d      = 1'b0;
          ch_ready_d = 1'b0;
          state_d    = StLoad;
`ifdef APUF_MAJVOTE_EN
          vote_d = '0;
          for (int i = 0; i < N_CHAIN; i++) begin
            ones_d[i] = '0;
          end
`endif
        end
      end
      StLoad: begin
        if (cnt_q == SettleLast) begin
          state_d = StFire;
          tig_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StFire: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        // All-ready is tested first so a simultaneous timeout is not flagged.
        if (rdy_all) begin
          state_d = StSample;
          tig_d   = 1'b0;
        end else if (cnt_inc == TmoCnt) begin
          err_d   = 1'b1;
          state_d = StSample;
          tig_d   = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StSample: begin
        state_d = StRelax;
        cnt_d   = '0;
        quiet_d = 1'b0;
`ifdef APUF_MAJVOTE_EN
        for (int i = 0; i < N_CHAIN; i++) begin
          ones_d[i] = ones_q[i] + VoteW'(bit_sync_q[i]);
        end
`else
        resp_raw_d = bit_sync_q;
        resp_bit_d = ^bit_sync_q;
`endif
      end
      StRelax: begin
        if (!quiet_q) begin
          if (rdy_none) begin
            quiet_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_inc == TmoCnt) begin
            err_d     = 1'b1;
            relax_tmo = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (cnt_q == SettleLast) begin
          relax_end = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
`ifdef APUF_MAJVOTE_EN
        done_entry = relax_tmo || (relax_end && (vote_q == VoteLast));
        if (done_entry) begin
          resp_raw_d = maj;
          resp_bit_d = ^maj;
        end else if (relax_end) begin
          // Challenge is already stable, so the next repetition skips LOAD.
          vote_d  = vote_q + VoteW'(1);
          state_d = StFire;
          tig_d   = 1'b1;
        end
`else
        done_entry = relax_tmo || relax_end;
`endif
        if (done_entry) begin
          state_d      = StDone;
          resp_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          ch_ready_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      quiet_q      <= 1'b0;
      err_q        <= 1'b0;
      chal_q       <= '0;
      tig_q        <= 1'b0;
      ch_ready_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_bit_q   <= 1'b0;
      resp_raw_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quiet_q      <= quiet_d;
      err_q        <= err_d;
      chal_q       <= chal_d;
      tig_q        <= tig_d;
      ch_ready_q   <= ch_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_bit_q   <= resp_bit_d;
      resp_raw_q   <= resp_raw_d;
    end
  end

  assign ch_ready   = ch_ready_q;
  assign chal_out   = chal_q;
  assign tig_out    = tig_q;
  assign resp_valid = resp_valid_q;
  assign resp_bit   = resp_bit_q;
  assign resp_raw   = resp_raw_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_apuf_xor_eval_ctrl.sv
// Self-checking bench for apuf_xor_eval_ctrl: behavioural chain model plus majority/XOR reference.
module tb_apuf_xor_eval_ctrl;

  localparam int unsigned N_STAGE    = 16;
  localparam int unsigned N_CHAIN    = 4;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned TIMEOUT_W  = 4;
  localparam int unsigned N_VOTE     = 5;
  localparam int          CHAIN_DLY  = 5;
`ifdef APUF_MAJVOTE_EN
  localparam int          NREP       = N_VOTE;
`else
  localparam int          NREP       = 1;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               ch_valid;
  logic               ch_ready;
  logic [N_STAGE-1:0] ch_data;
  logic [N_STAGE-1:0] chal_out;
  logic               tig_out;
  logic [N_CHAIN-1:0] chain_rdy;
  logic [N_CHAIN-1:0] chain_bit = '0;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_bit;
  logic [N_CHAIN-1:0] resp_raw;
  logic               resp_err;

  int n_checks = 0;
  int n_errors = 0;

  // Chain model: ready rises CHAIN_DLY cycles after the trigger unless stuck, bits per repetition.
  logic [N_CHAIN-1:0] rep_arr [NREP];
  logic [N_CHAIN-1:0] stuck = '0;
  int tig_age   = 0;
  int trig_cnt  = 0;
  int trig_base = 0;
  bit prev_high = 1'b0;
  int low_run   = 0;

  apuf_xor_eval_ctrl #(
    .N_STAGE   (N_STAGE),
    .N_CHAIN   (N_CHAIN),
    .SETTLE_CYC(SETTLE_CYC),
    .TIMEOUT_W (TIMEOUT_W),
    .N_VOTE    (N_VOTE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_data   (ch_data),
    .chal_out  (chal_out),
    .tig_out   (tig_out),
    .chain_rdy (chain_rdy),
    .chain_bit (chain_bit),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_bit  (resp_bit),
    .resp_raw  (resp_raw),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tig_out) begin
      if (tig_age == 0) begin
        chain_bit <= rep_arr[(trig_cnt - trig_base) % NREP];
        trig_cnt  <= trig_cnt + 1;
      end
      if (tig_age < 1000) tig_age <= tig_age + 1;
    end else begin
      tig_age <= 0;
    end
  end

  assign chain_rdy = (tig_age >= CHAIN_DLY) ? ~stuck : '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // One full evaluation: handshake, observe trigger, compare the response, optionally stall, accept.
  task automatic run_eval(input string tag, input logic [N_STAGE-1:0] chal, input int hold,
                          input bit tie_ready, output int first_len);
    int setup, pulses, waited, ones, t0;
    bit in_pulse, got_resp, chal_ok, gap_ok, excl_ok, stable;
    logic [N_CHAIN-1:0] exp_raw, keep_raw;
    logic keep_bit, keep_err;
    waited = 0;
    while (!ch_ready && waited < 100) begin
      cycle();
      waited++;
    end
    check_eq({tag, " ch_ready idle"}, ch_ready, 1'b1);
    trig_base = trig_cnt;
    ch_data   = chal;
    ch_valid  = 1'b1;
    cycle();
    ch_valid  = 1'b0;
    ch_data   = N_STAGE'($urandom);
    setup = 0; first_len = 0; pulses = 0; in_pulse = 0;
    got_resp = 0; chal_ok = 1; gap_ok = 1; excl_ok = 1;
    for (int c = 0; c < 800; c++) begin
      if (tig_out) begin
        if (!in_pulse) begin
          pulses++;
          if (chal_out !== chal) chal_ok = 0;
          if (prev_high && low_run < int'(SETTLE_CYC)) gap_ok = 0;
        end
        if (pulses == 1) first_len++;
        in_pulse  = 1;
        prev_high = 1;
        low_run   = 0;
      end else begin
        if (pulses == 0) setup++;
        in_pulse = 0;
        low_run++;
      end
      if (resp_valid && ch_ready) excl_ok = 0;
      if (resp_valid) begin
        got_resp = 1;
        break;
      end
      cycle();
    end
    check_eq({tag, " resp_valid seen"}, got_resp, 1'b1);
    for (int i = 0; i < N_CHAIN; i++) begin
      ones = 0;
      for (int r = 0; r < NREP; r++) ones += int'(rep_arr[r][i]);
      exp_raw[i] = (2 * ones > NREP);
    end
    check_eq({tag, " resp_raw"}, resp_raw, exp_raw);
    check_eq({tag, " resp_bit"}, resp_bit, ^exp_raw);
    check_eq({tag, " resp_err"}, resp_err, (stuck != '0));
    check_eq({tag, " settle before fire"}, setup, SETTLE_CYC);
    check_eq({tag, " trigger pulses"}, pulses, NREP);
    check_eq({tag, " chal_out at fire"}, chal_ok, 1'b1);
    check_eq({tag, " low gap"}, gap_ok, 1'b1);
    check_eq({tag, " valid/ready exclusive"}, excl_ok, 1'b1);
    if (hold > 0) begin
      keep_raw = resp_raw; keep_bit = resp_bit; keep_err = resp_err;
      t0 = trig_cnt;
      stable = 1;
      for (int h = 0; h < hold; h++) begin
        ch_valid = 1'b1;
        ch_data  = N_STAGE'($urandom);
        cycle();
        if (resp_valid !== 1'b1 || resp_raw !== keep_raw || resp_bit !== keep_bit ||
            resp_err !== keep_err || ch_ready !== 1'b0) stable = 0;
      end
      ch_valid = 1'b0;
      check_eq({tag, " held stable"}, stable, 1'b1);
      check_eq({tag, " no trigger in hold"}, trig_cnt, t0);
      check_eq({tag, " chal kept in hold"}, chal_out, chal);
    end
    resp_ready = 1'b1;
    cycle();
    resp_ready = tie_ready;
    check_eq({tag, " valid drops"}, resp_valid, 1'b0);
    check_eq({tag, " back to idle"}, ch_ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, t0;
    bit seen;
    logic [N_STAGE-1:0] chal;
    rst = 1'b1; ch_valid = 1'b0; ch_data = '0; resp_ready = 1'b0;
    for (int r = 0; r < NREP; r++) rep_arr[r] = 4'b1011;
    repeat (3) cycle();
    check_eq("reset ch_ready", ch_ready, 1'b1);
    check_eq("reset resp_valid", resp_valid, 1'b0);
    check_eq("reset tig_out", tig_out, 1'b0);
    check_eq("reset chal_out", chal_out, '0);
    check_eq("reset resp", {resp_bit, resp_raw, resp_err}, '0);
    rst = 1'b0;
    cycle();

    // Ideal chains, fixed pattern 1011.
    run_eval("ideal", 16'hA5C3, 0, 1'b0, len);

    // Stuck chain 2: WAIT times out after 2^TIMEOUT_W-1 cycles (plus the FIRE cycle).
    stuck = 4'b0100;
    run_eval("timeout", 16'h0F0F, 0, 1'b0, len);
    check_eq("timeout pulse length", len, 1 + (2 ** TIMEOUT_W) - 1);
    stuck = '0;

    // Consumer stalls 20 cycles while a new challenge is offered.
    for (int r = 0; r < NREP; r++) rep_arr[r] = 4'b0110;
    run_eval("hold", 16'h1234, 20, 1'b0, len);

    // Reset while waiting for stuck chains.
    stuck = '1;
    while (!ch_ready) cycle();
    ch_data = 16'hBEEF; ch_valid = 1'b1;
    cycle();
    ch_valid = 1'b0;
    repeat (SETTLE_CYC + 5) cycle();
    check_eq("rst: trigger high in wait", tig_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst: tig drops async", tig_out, 1'b0);
    check_eq("rst: resp_valid low", resp_valid, 1'b0);
    check_eq("rst: ch_ready high", ch_ready, 1'b1);
    cycle();
    rst = 1'b0;
    stuck = '0;
    prev_high = 1'b0;
    t0 = trig_cnt;
    seen = 0;
    repeat (60) begin
      cycle();
      if (resp_valid) seen = 1;
    end
    check_eq("rst: no response", seen, 1'b0);
    check_eq("rst: no trigger", trig_cnt, t0);
    check_eq("rst: idle", ch_ready, 1'b1);

    // Back-to-back with resp_ready tied high.
    resp_ready = 1'b1;
    for (int r = 0; r < NREP; r++) rep_arr[r] = 4'b1100;
    run_eval("b2b first", 16'h5555, 0, 1'b1, len);
    for (int r = 0; r < NREP; r++) rep_arr[r] = 4'b0111;
    run_eval("b2b second", 16'hAAAA, 0, 1'b1, len);
    resp_ready = 1'b0;

`ifdef APUF_MAJVOTE_EN
    begin
      logic [N_VOTE-1:0] seq;
      seq = 5'b01101;
      for (int r = 0; r < NREP; r++) rep_arr[r] = {3'b000, seq[r]};
      run_eval("vote", 16'h7E57, 0, 1'b0, len);
    end
`endif

    // Randomized evaluations.
    for (int k = 0; k < 8; k++) begin
      chal = N_STAGE'($urandom);
      for (int r = 0; r < NREP; r++) rep_arr[r] = N_CHAIN'($urandom);
      stuck = ($urandom_range(0, 3) == 0) ? N_CHAIN'(1 << $urandom_range(0, N_CHAIN - 1)) : '0;
      run_eval($sformatf("rand%0d", k), chal, $urandom_range(0, 3), 1'b0, len);
    end
    stuck = '0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
